// File: rtl/cu_pkg.sv
// Shared definitions for the microcoded control unit: opcodes, register-bank
// input selects, jump conditions, FSM state encoding and instruction fields.
// The WAIT state exists only when CU_SINGLE_STEP_EN is defined.
package cu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDA  = 4'h1;
    localparam logic [3:0] OP_LDB  = 4'h2;
    localparam logic [3:0] OP_LDI  = 4'h3;
    localparam logic [3:0] OP_MOV  = 4'h4;
    localparam logic [3:0] OP_ALU  = 4'h5;
    localparam logic [3:0] OP_JMP  = 4'h6;
    localparam logic [3:0] OP_JZ   = 4'h7;
    localparam logic [3:0] OP_JC   = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] SEL_INA   = 3'd0;
    localparam logic [2:0] SEL_INB   = 3'd1;
    localparam logic [2:0] SEL_CONST = 3'd2;
    localparam logic [2:0] SEL_ALU   = 3'd3;
    localparam logic [2:0] SEL_REG   = 3'd4;

    localparam logic [1:0] COND_ALWAYS = 2'd0;
    localparam logic [1:0] COND_Z      = 2'd1;
    localparam logic [1:0] COND_C      = 2'd2;

    // Instruction field bit positions
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int FLD_MSB = 7;
    localparam int FLD_LSB = 0;
    localparam int SUB_MSB = 3;
    localparam int SUB_LSB = 0;
    localparam int TGT_MSB = 11;
    localparam int TGT_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_HALT  = 3'd3
`ifdef CU_SINGLE_STEP_EN
        , ST_WAIT = 3'd4
`endif
    } state_e;

endpackage

// File: rtl/cu_decoder.sv
// Combinational instruction decoder. Maps one 16-bit instruction onto the
// register-bank controls plus the branch/halt indications. Ungated: the
// sequencer qualifies everything with the EXEC state.
module cu_decoder
    import cu_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [15:0]           instr_i,
    output logic                  we_o,
    output logic [2:0]            in_mux_add_o,
    output logic [3:0]            out_mux_add_o,
    output logic [3:0]            reg_add_o,
    output logic [3:0]            alu_op_o,
    output logic [DATA_WIDTH-1:0] cu_const_o,
    output logic                  is_jump_o,
    output logic [1:0]            jump_cond_o,
    output logic                  is_halt_o
);

    logic [3:0]            opcode;
    logic [3:0]            rd;
    logic [3:0]            sub;
    logic [DATA_WIDTH-1:0] imm_ext;

    assign opcode  = instr_i[OPC_MSB:OPC_LSB];
    assign rd      = instr_i[RD_MSB:RD_LSB];
    assign sub     = instr_i[SUB_MSB:SUB_LSB];
    // imm8 is zero-extended or truncated to the register-bank width
    assign imm_ext = DATA_WIDTH'(instr_i[FLD_MSB:FLD_LSB]);

    // Opcode decode; illegal opcodes 9..E fall into the default and act as NOP
    always_comb begin
        we_o          = 1'b0;
        in_mux_add_o  = SEL_INA;
        out_mux_add_o = 4'd0;
        reg_add_o     = 4'd0;
        alu_op_o      = 4'd0;
        cu_const_o    = '0;
        is_jump_o     = 1'b0;
        jump_cond_o   = COND_ALWAYS;
        is_halt_o     = 1'b0;
        case (opcode)
            OP_LDA: begin
                we_o         = 1'b1;
                in_mux_add_o = SEL_INA;
                reg_add_o    = rd;
            end
            OP_LDB: begin
                we_o         = 1'b1;
                in_mux_add_o = SEL_INB;
                reg_add_o    = rd;
            end
            OP_LDI: begin
                we_o         = 1'b1;
                in_mux_add_o = SEL_CONST;
                reg_add_o    = rd;
                cu_const_o   = imm_ext;
            end
            OP_MOV: begin
                we_o          = 1'b1;
                in_mux_add_o  = SEL_REG;
                reg_add_o     = rd;
                out_mux_add_o = sub;
            end
            OP_ALU: begin
                we_o         = 1'b1;
                in_mux_add_o = SEL_ALU;
                reg_add_o    = rd;
                alu_op_o     = sub;
            end
            OP_JMP: begin
                is_jump_o   = 1'b1;
                jump_cond_o = COND_ALWAYS;
            end
            OP_JZ: begin
                is_jump_o   = 1'b1;
                jump_cond_o = COND_Z;
            end
            OP_JC: begin
                is_jump_o   = 1'b1;
                jump_cond_o = COND_C;
            end
            OP_HALT: is_halt_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/cu_sequencer.sv
// Microcoded control unit: fetches from a 1-cycle-latency program ROM,
// executes one instruction every two cycles and drives the register-bank
// write port. Optional macro CU_SINGLE_STEP_EN adds a `step` input and a
// WAIT state after every EXEC.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | after reset; pc=0, waits for start
//   FETCH | prog_addr=pc presented to ROM; instr valid next cycle
//   EXEC  | instr decoded, controls driven for this cycle only, pc advances
//   HALT  | done=1; start restarts from pc=0 with cleared flags
//   WAIT  | (single-step only) busy, controls idle, leaves on step=1
module cu_sequencer
    import cu_pkg::*;
#(
    parameter int PC_WIDTH   = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
`ifdef CU_SINGLE_STEP_EN
    input  logic                  step,
`endif
    output logic [PC_WIDTH-1:0]   prog_addr,
    input  logic [15:0]           instr,
    input  logic                  alu_zero,
    input  logic                  alu_carry,
    output logic [3:0]            alu_op,
    output logic [2:0]            in_mux_add,
    output logic [3:0]            out_mux_add,
    output logic [3:0]            reg_add,
    output logic                  we,
    output logic [DATA_WIDTH-1:0] cu_const,
    output logic                  busy,
    output logic                  done
);

    state_e                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic                  z_q, z_d;
    logic                  c_q, c_d;
    logic                  busy_q, done_q;

    logic                  dec_we;
    logic [2:0]            dec_in_mux;
    logic [3:0]            dec_out_mux;
    logic [3:0]            dec_reg_add;
    logic [3:0]            dec_alu_op;
    logic [DATA_WIDTH-1:0] dec_const;
    logic                  dec_is_jump;
    logic [1:0]            dec_cond;
    logic                  dec_is_halt;

    logic                  in_exec;
    logic                  is_alu;
    logic                  cond_ok;
    logic                  jump_taken;
    logic [PC_WIDTH-1:0]   jump_tgt;

    cu_decoder #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_decoder (
        .instr_i       (instr),
        .we_o          (dec_we),
        .in_mux_add_o  (dec_in_mux),
        .out_mux_add_o (dec_out_mux),
        .reg_add_o     (dec_reg_add),
        .alu_op_o      (dec_alu_op),
        .cu_const_o    (dec_const),
        .is_jump_o     (dec_is_jump),
        .jump_cond_o   (dec_cond),
        .is_halt_o     (dec_is_halt)
    );

    assign in_exec  = (state_q == ST_EXEC);
    assign is_alu   = (instr[OPC_MSB:OPC_LSB] == OP_ALU);
    assign jump_tgt = PC_WIDTH'(instr[TGT_MSB:TGT_LSB]);

    // Branch condition evaluated against the latched flags, never live ALU inputs
    always_comb begin
        case (dec_cond)
            COND_Z:  cond_ok = z_q;
            COND_C:  cond_ok = c_q;
            default: cond_ok = 1'b1;
        endcase
        jump_taken = dec_is_jump & cond_ok;
    end

    // Next-state, program counter and flag computation
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        z_d     = z_q;
        c_d     = c_q;
        case (state_q)
            ST_IDLE: begin
                pc_d = '0;
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: state_d = ST_EXEC;
            ST_EXEC: begin
                pc_d = jump_taken ? jump_tgt : pc_q + PC_WIDTH'(1);
                if (is_alu) begin
                    z_d = alu_zero;
                    c_d = alu_carry;
                end
                if (dec_is_halt) begin
                    state_d = ST_HALT;
                end else begin
`ifdef CU_SINGLE_STEP_EN
                    state_d = ST_WAIT;
`else
                    state_d = ST_FETCH;
`endif
                end
            end
            ST_HALT: begin
                if (start) begin
                    pc_d    = '0;
                    z_d     = 1'b0;
                    c_d     = 1'b0;
                    state_d = ST_FETCH;
                end
            end
`ifdef CU_SINGLE_STEP_EN
            ST_WAIT: if (step) state_d = ST_FETCH;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // State register with registered status outputs derived from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            z_q     <= z_d;
            c_q     <= c_d;
`ifdef CU_SINGLE_STEP_EN
            busy_q  <= (state_d == ST_FETCH) || (state_d == ST_EXEC) || (state_d == ST_WAIT);
`else
            busy_q  <= (state_d == ST_FETCH) || (state_d == ST_EXEC);
`endif
            done_q  <= (state_d == ST_HALT);
        end
    end

    // Controls are only live during EXEC; an async reset leaves EXEC at once
    assign we          = in_exec & dec_we;
    assign in_mux_add  = in_exec ? dec_in_mux  : 3'd0;
    assign out_mux_add = in_exec ? dec_out_mux : 4'd0;
    assign reg_add     = in_exec ? dec_reg_add : 4'd0;
    assign alu_op      = in_exec ? dec_alu_op  : 4'd0;
    assign cu_const    = in_exec ? dec_const   : '0;

    assign prog_addr = pc_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
